lc3_decode_stage: RTL and testbench

//  Decode stage of the LC3 pipeline, directly downstream of fetch. Consumes fetch's npc
//  and the instruction word returned by instruction memory. Registers IR and npc, and

---
 rtl/lc3_decode_stage_if.sv | 21 ++
 rtl/lc3_decode_stage.sv | 74 +++++++
 tb/tb_lc3_decode_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/lc3_decode_stage_if.sv
// lc3_decode_stage_if: fetch/memory inputs and decoded control outputs of the LC3 decode stage
interface lc3_decode_stage_if #(parameter int DATA_W = 16);
  logic              enable_decode;
  logic [DATA_W-1:0] npc_in;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] IR;
  logic [DATA_W-1:0] npc_out;
  logic [5:0]        E_Control;
  logic [1:0]        W_Control;
  logic              Mem_Control;
  logic              decode_valid;
  logic              illegal_op;
  modport master (
    output enable_decode, npc_in, dout,
    input  IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op
  );
  modport slave (
    input  enable_decode, npc_in, dout,
    output IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_op
  );
endinterface

// File: rtl/lc3_decode_stage.sv
// lc3_decode_stage: latches IR/npc and decodes execute/writeback/memory controls from the incoming word
module lc3_decode_stage #(
  parameter int DATA_W = 16
) (
  input logic              clock,
  input logic              reset,
  lc3_decode_stage_if.slave bus
);
  logic [3:0]        w_op;
  logic [1:0]        w_alu;
  logic [1:0]        w_ps1;
  logic              w_ps2;
  logic              w_op2;
  logic [1:0]        w_wb;
  logic              w_mem;
  logic              w_ill;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_npc;
  logic [5:0]        r_e;
  logic [1:0]        r_w;
  logic              r_mem;
  logic              r_valid;
  logic              r_ill;
  // Decode from the incoming word, not the held IR, so controls line up with the new IR
  assign w_op  = bus.dout[DATA_W-1 -: 4];
  assign w_alu = (w_op == 4'b0101) ? 2'b01 : (w_op == 4'b1001) ? 2'b10 : 2'b00;
  assign w_op2 = ((w_op == 4'b0001) || (w_op == 4'b0101)) && !bus.dout[5];
  always_comb begin
    {w_ps1, w_ps2} = 3'b000;
    w_wb  = 2'd0;
    w_mem = 1'b0;
    w_ill = 1'b0;
    case (w_op)
      4'b0000, 4'b0011: {w_ps1, w_ps2} = 3'b011;
      4'b0010: begin {w_ps1, w_ps2} = 3'b011; w_wb = 2'd2; end
      4'b1010: begin {w_ps1, w_ps2} = 3'b011; w_wb = 2'd2; w_mem = 1'b1; end
      4'b1011: begin {w_ps1, w_ps2} = 3'b011; w_mem = 1'b1; end
      4'b1110: begin {w_ps1, w_ps2} = 3'b011; w_wb = 2'd1; end
      4'b0110: begin {w_ps1, w_ps2} = 3'b100; w_wb = 2'd2; end
      4'b0111: {w_ps1, w_ps2} = 3'b100;
      4'b1100: {w_ps1, w_ps2} = 3'b110;
      4'b0100, 4'b1000, 4'b1101, 4'b1111: w_ill = 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir    <= '0;
      r_npc   <= '0;
      r_e     <= '0;
      r_w     <= '0;
      r_mem   <= 1'b0;
      r_valid <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_valid <= bus.enable_decode;
      if (bus.enable_decode) begin
        r_ir  <= bus.dout;
        r_npc <= bus.npc_in;
        r_e   <= {w_alu, w_ps1, w_ps2, w_op2};
        r_w   <= w_wb;
        r_mem <= w_mem;
        r_ill <= w_ill;
      end
    end
  end
  assign bus.IR           = r_ir;
  assign bus.npc_out      = r_npc;
  assign bus.E_Control    = r_e;
  assign bus.W_Control    = r_w;
  assign bus.Mem_Control  = r_mem;
  assign bus.decode_valid = r_valid;
  assign bus.illegal_op   = r_ill;
endmodule

// File: tb/tb_lc3_decode_stage.sv
// tb_lc3_decode_stage: directed vectors, expected decodes queued at issue and checked by a monitor
module tb_lc3_decode_stage;
  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
    logic        ill;
  } exp_t;
  logic clock = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_chk  = 0;
  exp_t q[$];
  lc3_decode_stage_if #(.DATA_W(16)) bus ();
  lc3_decode_stage #(.DATA_W(16)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  function automatic exp_t outs();
    return {bus.IR, bus.npc_out, bus.E_Control, bus.W_Control, bus.Mem_Control, bus.illegal_op};
  endfunction
  task automatic check(string name, exp_t got, exp_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got ir=%h npc=%h e=%h w=%0d m=%b ill=%b, want ir=%h npc=%h e=%h w=%0d m=%b ill=%b",
                  name, got.ir, got.npc, got.e, got.w, got.m, got.ill,
                  want.ir, want.npc, want.e, want.w, want.m, want.ill);
  endtask
  task automatic check_bit(string name, logic got, logic want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, got, want);
  endtask
  task automatic cyc(input logic rs, input logic en, input logic [15:0] d, input logic [15:0] n);
    reset = rs;
    bus.enable_decode = en;
    bus.dout = d;
    bus.npc_in = n;
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic [15:0] d, input logic [15:0] n, input logic [5:0] e,
                       input logic [1:0] w, input logic m, input logic ill);
    q.push_back({d, n, e, w, m, ill});
    cyc(1'b0, 1'b1, d, n);
  endtask
  always @(negedge clock) begin
    if (bus.decode_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_valid: got decode_valid=1 with ir=%h, want no output", bus.IR);
      end else check("decode", outs(), q.pop_front());
    end
  end
  initial begin
    cyc(1'b1, 1'b1, 16'h1234, 16'h0000);
    cyc(1'b1, 1'b1, 16'h1234, 16'h0000);
    check("reset_outs", outs(), '0);
    check_bit("reset_valid", bus.decode_valid, 1'b0);
    issue(16'h12A3, 16'h3001, 6'h00, 2'd0, 1'b0, 1'b0);
    issue(16'h5705, 16'h3002, 6'h11, 2'd0, 1'b0, 1'b0);
    issue(16'hA005, 16'h3003, 6'h06, 2'd2, 1'b1, 1'b0);
    check_bit("b2b_valid", bus.decode_valid, 1'b1);
    issue(16'hC1C0, 16'h3004, 6'h0C, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'hE00F, 16'h3005);
    check("hold_outs", outs(), {16'hC1C0, 16'h3004, 6'h0C, 2'd0, 1'b0, 1'b0});
    check_bit("hold_valid", bus.decode_valid, 1'b0);
    cyc(1'b0, 1'b0, 16'hxxxx, 16'hxxxx);
    check("x_input_hold", outs(), {16'hC1C0, 16'h3004, 6'h0C, 2'd0, 1'b0, 1'b0});
    issue(16'hF025, 16'h3006, 6'h00, 2'd0, 1'b0, 1'b1);
    issue(16'hE00F, 16'h3007, 6'h06, 2'd1, 1'b0, 1'b0);
    issue(16'h927F, 16'h3008, 6'h20, 2'd0, 1'b0, 1'b0);
    issue(16'h1042, 16'h3009, 6'h01, 2'd0, 1'b0, 1'b0);
    issue(16'h0E05, 16'h300A, 6'h06, 2'd0, 1'b0, 1'b0);
    issue(16'h2205, 16'h300B, 6'h06, 2'd2, 1'b0, 1'b0);
    issue(16'h3205, 16'h300C, 6'h06, 2'd0, 1'b0, 1'b0);
    issue(16'h7245, 16'h300D, 6'h08, 2'd0, 1'b0, 1'b0);
    issue(16'hB205, 16'h300E, 6'h06, 2'd0, 1'b1, 1'b0);
    issue(16'h4000, 16'h300F, 6'h00, 2'd0, 1'b0, 1'b1);
    issue(16'h8000, 16'h3010, 6'h00, 2'd0, 1'b0, 1'b1);
    issue(16'hD000, 16'h3011, 6'h00, 2'd0, 1'b0, 1'b1);
    issue(16'h1042, 16'h3012, 6'h01, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'h6042, 16'h3013);
    check("reset_over_enable", outs(), '0);
    check_bit("reset_over_enable_valid", bus.decode_valid, 1'b0);
    issue(16'h6042, 16'h3014, 6'h08, 2'd2, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d pending decodes, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
